hilo_mac_unit: RTL and testbench

//  Multi-cycle HI/LO unit beside the EX-stage ALU; owns the MIPS HI/LO architectural registers.

---
 rtl/hilo_pkg.sv | 29 ++
 rtl/seq_mul_core.sv | 57 +++++
 rtl/hilo_mac_unit.sv | 122 ++++++++++++
 tb/tb_hilo_mac_unit.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// Shared op codes, FSM encodings and helpers for the HI/LO multiply unit.
package hilo_pkg;

    localparam logic [2:0] HILO_OP_NOP   = 3'b000;
    localparam logic [2:0] HILO_OP_MULT  = 3'b001;
    localparam logic [2:0] HILO_OP_MULTU = 3'b010;
    localparam logic [2:0] HILO_OP_MADD  = 3'b011;
    localparam logic [2:0] HILO_OP_MSUB  = 3'b100;
    localparam logic [2:0] HILO_OP_MTHI  = 3'b101;
    localparam logic [2:0] HILO_OP_MTLO  = 3'b110;
    localparam logic [2:0] HILO_OP_NOP7  = 3'b111;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_ACC  = 2'd2;

    // True for the ops that run through the multi-cycle multiplier.
    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == HILO_OP_MULT) || (op == HILO_OP_MULTU) ||
               (op == HILO_OP_MADD) || (op == HILO_OP_MSUB);
    endfunction

    // Signed ops work on magnitudes and fix the sign afterwards.
    function automatic logic is_signed_op(input logic [2:0] op);
        return (op == HILO_OP_MULT) || (op == HILO_OP_MADD) ||
               (op == HILO_OP_MSUB);
    endfunction

endpackage

// File: rtl/seq_mul_core.sv
// Radix-2 shift-add unsigned multiplier: one multiplier bit per cycle, LSB first.
// Load captures the operands and clears the product; the core then iterates
// WIDTH times on its own and raises Last during the final iteration.
module seq_mul_core #(
    parameter int WIDTH = 32
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Load,
    input  logic [WIDTH-1:0]   Mcand,
    input  logic [WIDTH-1:0]   Mplier,
    output logic [2*WIDTH-1:0] Prod,
    output logic               Last
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] prod_q;
    logic [CW-1:0]      cnt;
    logic               active;
    logic [WIDTH:0]     upper_sum;

    // Upper half plus (optionally) the multiplicand, keeping the carry bit.
    always_comb begin
        upper_sum = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                    {1'b0, (mplier_q[0] ? mcand_q : {WIDTH{1'b0}})};
    end

    assign Last = active && (cnt == CW'(WIDTH - 1));
    assign Prod = prod_q;

    // Operand capture on Load, then one add/shift step per cycle while active.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt      <= '0;
            active   <= 1'b0;
        end else if (Load) begin
            mcand_q  <= Mcand;
            mplier_q <= Mplier;
            prod_q   <= '0;
            cnt      <= '0;
            active   <= 1'b1;
        end else if (active) begin
            prod_q   <= {upper_sum, prod_q[WIDTH-1:1]};
            mplier_q <= mplier_q >> 1;
            cnt      <= cnt + 1'b1;
            if (Last)
                active <= 1'b0;
        end
    end

endmodule

// File: rtl/hilo_mac_unit.sv
// HI/LO unit beside the EX-stage ALU: owns HI/LO, runs MULT/MULTU/MADD/MSUB
// through a sequential multiplier and handles MTHI/MTLO in one cycle.
module hilo_mac_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy,
    output logic             Done
);

    logic [1:0]         state;
    logic [2:0]         op_q;
    logic               neg_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               busy_q;
    logic               done_q;

    logic               accept;
    logic               sgn;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] prod;
    logic               last;
    logic [2*WIDTH-1:0] p_signed;
    logic [2*WIDTH-1:0] hilo_cur;
    logic [2*WIDTH-1:0] hilo_next;

    // Requests are only looked at in IDLE; anything during Busy is dropped.
    assign accept = (state == S_IDLE) && Start && is_mul_op(Op);
    assign sgn    = is_signed_op(Op);

    // Magnitudes for the signed ops; the most-negative value maps to 2^(W-1) unsigned.
    always_comb begin
        mag_a  = A[WIDTH-1] ? (~A + 1'b1) : A;
        mag_b  = B[WIDTH-1] ? (~B + 1'b1) : B;
        mcand  = sgn ? mag_a : A;
        mplier = sgn ? mag_b : B;
    end

    seq_mul_core #(.WIDTH(WIDTH)) u_core (
        .Clk    (Clk),
        .Rst    (Rst),
        .Load   (accept),
        .Mcand  (mcand),
        .Mplier (mplier),
        .Prod   (prod),
        .Last   (last)
    );

    // Sign fix-up of the unsigned product and the MADD/MSUB accumulate, mod 2^(2W).
    always_comb begin
        hilo_cur = {hi_q, lo_q};
        p_signed = neg_q ? (~prod + 1'b1) : prod;
        case (op_q)
            HILO_OP_MADD: hilo_next = hilo_cur + p_signed;
            HILO_OP_MSUB: hilo_next = hilo_cur - p_signed;
            default:      hilo_next = p_signed;
        endcase
    end

    // FSM IDLE -> MUL (WIDTH cycles) -> ACC (one cycle); owns Hi/Lo, Busy and Done.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state  <= S_IDLE;
            op_q   <= HILO_OP_NOP;
            neg_q  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q   <= Op;
                        neg_q  <= sgn & (A[WIDTH-1] ^ B[WIDTH-1]);
                        busy_q <= 1'b1;
                        state  <= S_MUL;
                    end else if (Start && (Op == HILO_OP_MTHI)) begin
                        hi_q <= A;
                    end else if (Start && (Op == HILO_OP_MTLO)) begin
                        lo_q <= A;
                    end
                end
                S_MUL: begin
                    if (last)
                        state <= S_ACC;
                end
                S_ACC: begin
                    hi_q   <= hilo_next[2*WIDTH-1:WIDTH];
                    lo_q   <= hilo_next[WIDTH-1:0];
                    done_q <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign Hi   = hi_q;
    assign Lo   = lo_q;
    assign Busy = busy_q;
    assign Done = done_q;

endmodule

// File: tb/tb_hilo_mac_unit.sv
// Scoreboard bench for hilo_mac_unit: stimulus pushes expected {Hi,Lo} per
// multiply-class op, a monitor pops and compares on every Done pulse.
module tb_hilo_mac_unit;

    localparam int W = 32;

    logic          Clk = 1'b0;
    logic          Rst;
    logic          Start;
    logic [2:0]    Op;
    logic [W-1:0]  A;
    logic [W-1:0]  B;
    logic [W-1:0]  Hi;
    logic [W-1:0]  Lo;
    logic          Busy;
    logic          Done;

    int checks   = 0;
    int failures = 0;
    logic [2*W-1:0] sb[$];

    hilo_mac_unit #(.WIDTH(W)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .Start (Start),
        .Op    (Op),
        .A     (A),
        .B     (B),
        .Hi    (Hi),
        .Lo    (Lo),
        .Busy  (Busy),
        .Done  (Done)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every Done must match the oldest outstanding expectation.
    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (Done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", {Hi, Lo}, 64'h0);
                    checks++;
                    failures++;
                    $display("FAIL stray_done actual=1 required=0");
                end else begin
                    chk("result", {Hi, Lo}, sb.pop_front());
                end
            end
        end
    end

    // Issue a multiply-class op (called #1 after a posedge) and wait for Done.
    task automatic mul_op(input logic [2:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [63:0] exp);
        logic [63:0] old;
        int n;
        old = {Hi, Lo};
        sb.push_back(exp);
        Op = op; A = a; B = b; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0; Op = 3'b000; A = 32'h5A5A5A5A; B = 32'hA5A5A5A5;
        chk("busy_k1", {63'd0, Busy}, 64'd1);
        chk("hold_k1", {Hi, Lo}, old);
        n = 0;
        while (!Done && n < 100) begin
            @(posedge Clk); #1;
            n++;
        end
        chk("latency", n, W + 1);
        chk("busy_done", {63'd0, Busy}, 64'd0);
    endtask

    // Single-cycle MTHI/MTLO.
    task automatic mt_op(input logic [2:0] op, input logic [W-1:0] a, input logic [63:0] exp);
        Op = op; A = a; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0; Op = 3'b000;
        chk("mt_value", {Hi, Lo}, exp);
        chk("mt_flags", {62'd0, Busy, Done}, 64'd0);
    endtask

    initial begin
        Rst = 1'b1; Start = 1'b1; Op = 3'b101; A = 32'hFFFFFFFF; B = 32'h0;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0; Start = 1'b0; Op = 3'b000;
        chk("reset_hilo", {Hi, Lo}, 64'h0);
        chk("reset_flags", {62'd0, Busy, Done}, 64'd0);

        // NOP codes have no effect.
        mt_op(3'b000, 32'h11111111, 64'h0);
        mt_op(3'b111, 32'h22222222, 64'h0);

        mul_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001);
        mul_op(3'b001, 32'hFFFFFFFD, 32'h00000007, 64'hFFFFFFFF_FFFFFFEB);
        mul_op(3'b001, 32'h80000000, 32'h80000000, 64'h40000000_00000000);
        mul_op(3'b010, 32'h00000000, 32'h12345678, 64'h0);

        mt_op(3'b101, 32'h00000001, 64'h00000001_00000000);
        mt_op(3'b110, 32'hFFFFFFFF, 64'h00000001_FFFFFFFF);
        mul_op(3'b011, 32'h00000001, 32'h00000001, 64'h00000002_00000000);
        mul_op(3'b100, 32'h00000001, 32'h00000001, 64'h00000001_FFFFFFFF);

        // Starts during Busy are ignored.
        sb.push_back(64'hFFFFFFFF_FFFFFFEC);
        Op = 3'b001; A = 32'h5; B = 32'hFFFFFFFC; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (4) begin @(posedge Clk); #1; end
        Op = 3'b110; A = 32'h0000DEAD; Start = 1'b1;
        @(posedge Clk); #1;
        Op = 3'b010; A = 32'h2; B = 32'h3;
        @(posedge Clk); #1;
        Start = 1'b0; Op = 3'b000;
        chk("ignore_hold", {Hi, Lo}, 64'h00000001_FFFFFFFF);
        chk("ignore_busy", {63'd0, Busy}, 64'd1);
        begin
            int n = 0;
            while (!Done && n < 100) begin @(posedge Clk); #1; n++; end
            chk("ignore_done_seen", {63'd0, Done}, 64'd1);
        end
        repeat (40) begin @(posedge Clk); #1; end
        chk("ignore_no_second", {Hi, Lo}, 64'hFFFFFFFF_FFFFFFEC);

        // Reset in the middle of a MADD.
        mt_op(3'b101, 32'h00001234, 64'h00001234_FFFFFFEC);
        mt_op(3'b110, 32'h00005678, 64'h00001234_00005678);
        Op = 3'b011; A = 32'h3; B = 32'h4; Start = 1'b1;
        @(posedge Clk); #1;
        Start = 1'b0;
        repeat (9) begin @(posedge Clk); #1; end
        Rst = 1'b1;
        @(posedge Clk); #1;
        Rst = 1'b0;
        chk("abort_hilo", {Hi, Lo}, 64'h0);
        chk("abort_flags", {62'd0, Busy, Done}, 64'd0);
        repeat (40) begin @(posedge Clk); #1; end
        chk("abort_hilo_late", {Hi, Lo}, 64'h0);
        mul_op(3'b001, 32'h6, 32'h7, 64'h00000000_0000002A);

        repeat (3) begin @(posedge Clk); #1; end
        chk("sb_empty", sb.size(), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
